// File: rtl/byte_decode_stream_if.sv
// Byte-in / coefficient-out stream bundle for byte_decode_stream.
// slave  : the decoder side (consumes bytes, produces coefficients).
// master : the producer/consumer around the decoder.
interface byte_decode_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_coeff;
    logic        out_last;

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_coeff, out_last
    );

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_coeff, out_last
    );
endinterface

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d: one byte in per handshake, LSB-first bit stream,
// one D-bit coefficient out per handshake, N_COEFF coefficients per polynomial.
// Optional feature macro: BYTE_DECODE_MODQ_EN (D==12 only) reduces raw values
// >= Q by a single subtract and flags range_err.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; range_err keeps last polynomial's value
// RUN     | accepting bytes / emitting coefficients
// DONE    | one-cycle completion pulse, then back to IDLE
module byte_decode_stream #(
    parameter int D       = 12,
    parameter int N_COEFF = 256,
    parameter int Q       = 3329
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    byte_decode_stream_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 range_err
);

    generate
        if (D < 1 || D > 12 || Q < 1) begin : g_bad_param
            $error("byte_decode_stream: D must be 1..12 and Q positive");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [8:0] BYTE_TOTAL = 9'(32 * D);
    localparam logic [8:0] LAST_IDX   = 9'(N_COEFF - 1);
    localparam logic [4:0] D_W        = 5'(D);

    logic [1:0]  state;
    logic [19:0] acc;
    logic [4:0]  bit_cnt;
    logic [8:0]  byte_cnt;
    logic [8:0]  coeff_cnt;
    logic        range_err_q;

    logic        run;
    logic        in_ready_c;
    logic        out_valid_c;
    logic        push;
    logic        pop;
    logic [11:0] raw;
    logic [11:0] coeff;
    logic        over_q;

    assign run         = (state == ST_RUN);
    // Never both: a pop needs bit_cnt >= D, a push needs bit_cnt < D.
    assign in_ready_c  = run && (bit_cnt < D_W) && (byte_cnt < BYTE_TOTAL);
    assign out_valid_c = run && (bit_cnt >= D_W);
    assign push        = bus.in_valid && in_ready_c;
    assign pop         = out_valid_c && bus.out_ready;

    // Zero-extend the low D bits of the accumulator to the 12-bit output.
    always_comb begin
        raw        = '0;
        raw[D-1:0] = acc[D-1:0];
    end

`ifdef BYTE_DECODE_MODQ_EN
    generate
        if (D == 12) begin : g_modq
            localparam logic [11:0] Q_W = 12'(Q);
            // raw <= 4095 < 2Q, so one conditional subtract fully reduces it.
            assign over_q = (raw >= Q_W);
            assign coeff  = over_q ? (raw - Q_W) : raw;
        end else begin : g_raw
            assign over_q = 1'b0;
            assign coeff  = raw;
        end
    endgenerate
`else
    assign over_q = 1'b0;
    assign coeff  = raw;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_coeff = coeff;
    assign bus.out_last  = out_valid_c && (coeff_cnt == LAST_IDX);
    assign busy          = run;
    assign done          = (state == ST_DONE);
    assign range_err     = range_err_q;

    // FSM plus accumulator/counters; push and pop are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            coeff_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        acc       <= '0;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        coeff_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        acc      <= acc | ({12'b0, bus.in_byte} << bit_cnt);
                        bit_cnt  <= bit_cnt + 5'd8;
                        byte_cnt <= byte_cnt + 9'd1;
                    end else if (pop) begin
                        acc       <= acc >> D;
                        bit_cnt   <= bit_cnt - D_W;
                        coeff_cnt <= coeff_cnt + 9'd1;
                        if (coeff_cnt == LAST_IDX) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky out-of-range flag, cleared when a new polynomial starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            range_err_q <= 1'b0;
        end else if (pop && over_q) begin
            range_err_q <= 1'b1;
        end
    end

endmodule
